// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Contents: FSM state enum, JMPSel encodings, NOP word, skid/IF-ID entry struct,
//           word-alignment helper used for every address that leaves the stage.
package fetch_pkg;

  // S_REQ  : request at PC is (or will be) on the memory port
  // S_DRAIN: a redirected request is still waiting for imem_ready; its data is dropped
  // S_HOLD : stalled with a fetched word parked in the skid buffer
  typedef enum logic [1:0] {
    S_REQ   = 2'b00,
    S_DRAIN = 2'b01,
    S_HOLD  = 2'b10
  } fetch_state_t;

  localparam logic [1:0]  JMP_SEQ  = 2'b00;
  localparam logic [1:0]  JMP_ABS  = 2'b01;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low bits of targets are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry parking register for a word fetched while decode is stalled.
// Latency: load/clear take effect on the next rising edge; contents visible one cycle later.
// Backpressure: none internally; the owner must not load while full (clear wins over load).
// Ports: clk, rst (async high), load_i, clear_i, entry_i -> entry_o, full_o.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         full_o
);

  fetch_entry_t entry_q;
  logic         full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      // Data is left in place; only the full flag matters to the reader.
      full_q <= 1'b0;
    end else if (load_i) begin
      entry_q <= entry_i;
      full_q  <= 1'b1;
    end
  end

  assign entry_o = entry_q;
  assign full_o  = full_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues ready-handshaked imem requests, fills the IF/ID register.
// Latency: request to instruction on the outputs = memory wait cycles + 1 (1 instr/cycle at zero wait).
// Backpressure: stall parks one fetched word in a skid buffer and drops imem_req until released.
// Ports: clk, rst (async high); stall; JMPSel/Address (decode jump); BranchTaken/BranchTarget
//        (execute redirect); imem_req/imem_addr/imem_ready/imem_rdata (memory port);
//        instruction/PC_D/valid_D (IF/ID register to decode).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  JMPSel,
  input  logic [31:0] Address,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC_D,
  output logic        valid_D
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcd_q, pcd_d;
  logic         vld_q, vld_d;

  logic         req;
  logic         hs;
  logic         jmp_take;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  fetch_addr;

  logic         buf_load;
  logic         buf_clear;
  logic         buf_full;
  fetch_entry_t buf_entry;
  fetch_entry_t buf_in;

  // ---------------------------------------------------------------------------
  // Memory port
  // ---------------------------------------------------------------------------
  assign req        = (state_q != S_HOLD);
  // The state register already sits in S_REQ during reset; gate so the port is idle.
  assign imem_req   = req & ~rst;
  assign fetch_addr = word_align(pc_q);
  // While draining, PC may already hold the redirect target, so the abandoned
  // address is replayed from its own register to keep the request stable.
  assign imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : fetch_addr;
  assign hs         = req & imem_ready;

  // ---------------------------------------------------------------------------
  // Redirect selection: branch from execute beats a jump from decode.
  // A jump only counts for a real instruction that decode is actually consuming.
  // ---------------------------------------------------------------------------
  assign jmp_take = (JMPSel == JMP_ABS) & vld_q & ~stall;
  assign redirect = BranchTaken | jmp_take;
  assign target   = word_align(BranchTaken ? BranchTarget : Address);

  assign buf_in.instr = imem_rdata;
  assign buf_in.pc    = fetch_addr;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .entry_i (buf_in),
    .entry_o (buf_entry),
    .full_o  (buf_full)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    vld_d        = vld_q;
    buf_load     = 1'b0;
    buf_clear    = 1'b0;

    case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d      = target;
          instr_d   = NOP_INSTR;
          pcd_d     = '0;
          vld_d     = 1'b0;
          buf_clear = 1'b1;
          // A request that is not accepted this edge must still complete; its data is junk.
          if (!imem_ready) begin
            state_d      = S_DRAIN;
            drain_addr_d = fetch_addr;
          end
        end else if (hs) begin
          pc_d = pc_q + PC_STEP;
          if (stall) begin
            buf_load = 1'b1;
            state_d  = S_HOLD;
          end else begin
            instr_d = imem_rdata;
            pcd_d   = fetch_addr;
            vld_d   = 1'b1;
          end
        end else if (!stall) begin
          // Decode consumed the slot and nothing arrived: insert a bubble.
          instr_d = NOP_INSTR;
          pcd_d   = '0;
          vld_d   = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d      = target;
          instr_d   = NOP_INSTR;
          pcd_d     = '0;
          vld_d     = 1'b0;
          buf_clear = 1'b1;
          state_d   = S_REQ;
        end else if (!stall && buf_full) begin
          instr_d   = buf_entry.instr;
          pcd_d     = buf_entry.pc;
          vld_d     = 1'b1;
          buf_clear = 1'b1;
          state_d   = S_REQ;
        end
      end

      S_DRAIN: begin
        // IF/ID was flushed on entry and stays a bubble; later redirects only move PC.
        if (redirect) begin
          pc_d = target;
        end
        if (hs) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      instr_q      <= NOP_INSTR;
      pcd_q        <= '0;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      vld_q        <= vld_d;
    end
  end

  assign instruction = instr_q;
  assign PC_D        = pcd_q;
  assign valid_D     = vld_q;

  // An outstanding request keeps its address until the memory accepts it.
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr)));

  // Holding state always has a parked word.
  a_hold_full: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_HOLD) |-> buf_full);

endmodule
